// File: rtl/iterative_mdu_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The requester drives start/op/a/b; the unit returns busy/done/result.
interface iterative_mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/iterative_mdu.sv
// Iterative RV32M-style multiply/divide unit: XLEN shift-add or restoring
// shift-subtract steps on operand magnitudes, sign fixed up on the way to DONE.
module iterative_mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  iterative_mdu_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [CW-1:0]   cnt;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Operand magnitudes and final sign, decided at the accepting edge
  logic            a_sgn;
  logic            b_sgn;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            neg_c;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.op)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = bus.a[XLEN-1];
        b_sgn = bus.b[XLEN-1];
      end
      3'b010:  a_sgn = bus.a[XLEN-1];
      default: ;
    endcase
    a_mag = a_sgn ? XLEN'(-bus.a) : bus.a;
    b_mag = b_sgn ? XLEN'(-bus.b) : bus.b;
    // Remainder follows the dividend; everything else follows the product of signs
    neg_c = (bus.op == 3'b110) ? a_sgn : (a_sgn ^ b_sgn);
  end

  // One iteration step for each algorithm; acc_hi/acc_lo hold product or remainder/quotient
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin;

  always_comb begin
    prod = neg_q ? (2*XLEN)'(-{acc_hi, acc_lo}) : {acc_hi, acc_lo};
    quo  = neg_q ? XLEN'(-acc_lo) : acc_lo;
    rem  = neg_q ? XLEN'(-acc_hi) : acc_hi;
    case (op_q)
      3'b000:                 fin = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
      // A zero divisor leaves the dividend magnitude in acc_hi, so REM needs no override
      3'b100, 3'b101:         fin = (opnd == '0) ? '1 : quo;
      default:                fin = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= CALC;
            busy_q <= 1'b1;
            op_q   <= bus.op;
            neg_q  <= neg_c;
            cnt    <= '0;
            acc_hi <= '0;
            if (bus.op[2]) begin
              opnd   <= b_mag;
              acc_lo <= a_mag;
            end else begin
              opnd   <= a_mag;
              acc_lo <= b_mag;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt == CW'(XLEN)) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin;
          end else begin
            cnt <= cnt + CW'(1);
            if (!op_q[2]) begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
            end else if (!div_diff[XLEN]) begin
              acc_hi <= div_diff[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_mdu.sv
// Scoreboard bench for iterative_mdu: driver queues reference results,
// a forked monitor pops them when done pulses and checks value and latency.
module tb_iterative_mdu;
  localparam int unsigned XLEN = 32;
  // Negedge before the accepting edge to the negedge where done is visible
  localparam int LAT = XLEN + 2;

  logic clk = 1'b0;
  logic reset;

  iterative_mdu_if #(.XLEN(XLEN)) bus ();

  iterative_mdu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  op;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model from the ISA rules using 64-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.done) begin
        check("done_without_busy", 64'(bus.busy), 64'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result_op%0d", e.op), 64'(bus.result), 64'(e.res));
          check("latency", 64'(cyc), 64'(e.due));
          last_res = e.res;
        end
      end
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int pulse_at);
    exp_t e;
    bit   seen;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.res = ref_mdu(op, a, b);
    e.due = cyc + LAT;
    e.op  = op;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    seen = 1'b0;
    for (int k = 0; k < int'(XLEN) + 8 && !seen; k++) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        check("busy_in_calc", 64'(bus.busy), 64'(1));
        check("result_stable", 64'(bus.result), 64'(last_res));
        if (k == pulse_at) begin
          bus.start = 1'b1;
          bus.op    = 3'b100;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!seen) check("done_timeout", 64'(bus.done), 64'(1));
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_done", 64'(bus.done), 64'(0));
    check("idle_busy", 64'(bus.busy), 64'(0));
  endtask

  logic [2:0]  d_op[12] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0};
  logic [31:0] d_a[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                            32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};

  initial begin
    bit          seen;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    fork
      monitor();
    join_none

    #1;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_result", 64'(bus.result), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Start on the very first edge after release
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
    idle_check();

    foreach (d_op[i]) begin
      do_op(d_op[i], d_a[i], d_b[i], -1);
      idle_check();
    end

    // Ignored start mid-CALC, then a back-to-back start during DONE
    do_op(3'd0, 32'd3, 32'd4, 10);
    do_op(3'd4, 32'd12, 32'd4, -1);
    idle_check();

    // Asynchronous reset mid-CALC
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_result", 64'(bus.result), 64'(0));
    last_res = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("no_done_after_abort", 64'(seen), 64'(0));
    do_op(3'd6, 32'hFFFF_FF9C, 32'd7, -1);
    idle_check();

    // Randomized operations with occasional corner operands and back-to-back starts
    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(7, 0))
        0: r_b = '0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(15, 1));
        3: r_a = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(r_op, r_a, r_b, -1);
      if ($urandom_range(1, 0) == 1) idle_check();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_mdu.md
ITERATIVE_MDU -- requirements
Module: iterative_mdu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width in bits (legal values: even, 8..64).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to launch an operation, sampled on a rising clk edge.
REQ-005 The block SHALL have port op  input  3  operation select in RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port a  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-007 The block SHALL have port b  input  XLEN  rs2 operand (divisor / multiplier).
REQ-008 The block SHALL have port busy  output  1  operation in progress, new start ignored.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 The block SHALL have port result  output  XLEN  operation result, held until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; acceptance latches op, a and b internally and enters CALC.
REQ-013 start SHALL be ignored while in CALC, with no effect on the in-flight operation.
REQ-014 In CALC the block SHALL run exactly XLEN iterations: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-015 After the final iteration the FSM SHALL enter DONE for exactly one cycle, then return to IDLE unless start is accepted.
REQ-016 Latency SHALL be fixed for every op and operand value: done=1 in the cycle following the (XLEN+1)th rising edge after the edge that accepted start.
REQ-017 busy SHALL be 1 exactly while in CALC.
REQ-018 done SHALL be 1 exactly while in DONE.
REQ-019 result SHALL update only on entry to DONE; it is stable in DONE, in IDLE and throughout a following CALC.
REQ-020 Signed ops SHALL operate on magnitudes with the sign applied at completion. MULH: a and b signed; MULHSU: a signed, b unsigned; MULHU: both unsigned.
REQ-021 MUL SHALL return the low XLEN bits of the 2*XLEN product; the MULH variants SHALL return the high XLEN bits.
REQ-022 DIV/REM SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-023 Divide by zero: DIV/DIVU SHALL return all ones and REM/REMU SHALL return a, with unchanged latency.
REQ-024 Signed overflow (a = most-negative, b = -1): DIV SHALL return a and REM SHALL return 0, with unchanged latency.
REQ-025 Inputs a, b and op SHALL be don't-care outside the accepting edge.
REQ-026 Back-to-back operation: start asserted during DONE SHALL be accepted, and busy rises the next cycle with no IDLE gap.

Reset
REQ-027 While reset=1, regardless of clk, the FSM SHALL be IDLE and busy=0, done=0, result=0, with all internal registers cleared.
REQ-028 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start accepted after release behaves as from power-up.
REQ-029 start sampled on the first edge after reset deasserts SHALL be accepted normally.

Verification (XLEN=32)
REQ-030 MUL a=7, b=0xFFFFFFFD: start at edge N -> busy for edges N+1..N+32, done=1 in the single cycle after edge N+33, result=0xFFFFFFEB.
REQ-031 MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFF.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD; REM with the same operands -> result=0xFFFFFFFF; DIVU a=100, b=7 -> result=14; REMU with the same operands -> result=2.
REQ-033 DIVU a=5, b=0 -> result=0xFFFFFFFF; REMU a=5, b=0 -> result=5; DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM with the same operands -> result=0; all with 33-edge latency.
REQ-034 Start MUL 3*4, pulse start with DIV ops at CALC cycle 10 -> ignored, result=12 at the normal time; start DIV 12/4 in the DONE cycle -> busy next cycle, result=3 after 33 edges.
REQ-035 Assert reset asynchronously (between edges) at CALC cycle 15 -> busy=0, done=0, result=0 immediately; no done pulse appears after release; the next operation completes with correct value and latency.
